// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Hazard unit for a five-stage pipeline (F/D/E/M/W) with an iterative
// multiplier that occupies Execute for MUL_CYCLES cycles.
//
// Parameter
//   MUL_CYCLES   Execute-stage occupancy of a multiply in cycles (2..16).
//
// Configuration macro
//   HAZARD_FWD_EN  defined   : M/W -> E operand forwarding is generated.
//                  undefined : forwarding selects are tied to 00 and any
//                              Decode read of a register still being written
//                              by E or M stalls Decode (W writes first half
//                              of the cycle, so a W match needs no stall).
//
// Ports
//   clk                        sole clock, all state on the rising edge
//   reset                      asynchronous, active-low
//   RA1D, RA2D                 Decode source registers
//   RA1E, RA2E                 Execute source registers
//   WA3E, WA3M, WA3W           destination registers in E/M/W
//   RegWriteE/M/W              register write enables in E/M/W
//   MemtoRegE                  load in Execute
//   PCSrcD/E/M/W               instruction writing the PC in that stage
//   BranchTakenE               taken branch resolved in Execute
//   MulStartE                  multiply present in Execute
//   ForwardAE, ForwardBE       00 regfile, 01 ResultW, 10 ALUResultM
//   StallF, StallD, StallE     hold the stage register
//   FlushD, FlushE, FlushM     load a bubble into the stage register
//   MulBusy                    multiplier occupied (stalling) this cycle
//   MulDoneE                   multiply result valid this cycle
//   dbg_state                  multiplier FSM state: 0 IDLE, 1 BUSY, 2 DONE
//   dbg_cnt                    multiplier down-counter
//
// Handshake: there is no valid/ready pair here. MulStartE is a level that is
// honoured only in IDLE; while the multiplier is BUSY/DONE the same
// instruction is still sitting in Execute, so MulStartE is ignored.
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulBusy,
  output logic       MulDoneE,
  output logic [1:0] dbg_state,
  output logic [3:0] dbg_cnt
);

  if (MUL_CYCLES < 2 || MUL_CYCLES > 16) begin : g_bad_param
    $error("hazard_controller: MUL_CYCLES must be in 2..16");
  end

  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 2);
  localparam logic [3:0] PC_REG   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  mul_state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       mul_stall;
  logic       mul_done;

  // ---------------------------------------------------------------------------
  // Multiplier sequencing
  // The IDLE cycle in which MulStartE appears is the first stall cycle, so
  // BUSY must last MUL_CYCLES-2 cycles. cnt is loaded with MUL_CYCLES-2 and
  // BUSY hands over to DONE on the cycle in which it decrements to zero.
  // With MUL_CYCLES==2 there is no BUSY cycle at all: IDLE goes straight to
  // DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mul_stall  = 1'b0;
    mul_done   = 1'b0;
    case (state)
      IDLE: begin
        if (MulStartE) begin
          mul_stall = 1'b1;
          cnt_next  = CNT_LOAD;
          if (CNT_LOAD == 4'd0) state_next = DONE;
          else                  state_next = BUSY;
        end
      end
      BUSY: begin
        mul_stall = 1'b1;
        if (cnt != 4'd0) cnt_next = cnt - 4'd1;
        // cnt<=1 rather than ==1 so a corrupted zero count still terminates
        if (cnt <= 4'd1) state_next = DONE;
      end
      DONE: begin
        // Same instruction still in Execute: MulStartE is not a new request.
        mul_done   = 1'b1;
        cnt_next   = 4'd0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign MulBusy   = mul_stall;
  assign MulDoneE  = mul_done;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  // ---------------------------------------------------------------------------
  // Data hazards
  // ---------------------------------------------------------------------------
  logic ldr_stall;
  logic raw_stall;
  logic pc_wr_pending;

  assign ldr_stall     = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

`ifdef HAZARD_FWD_EN
  // M is the younger producer, so it takes priority over W. R15 is the PC
  // and is read from its own path, never from the forwarding network.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != PC_REG) begin
      if (RegWriteM && (WA3M == src))      sel = 2'b10;
      else if (RegWriteW && (WA3W == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(RA1E);
  assign ForwardBE = fwd_sel(RA2E);
  assign raw_stall = 1'b0;

  logic unused_nofwd;
  assign unused_nofwd = RegWriteE;
`else
  // Without forwarding Decode must wait until the producer reaches W.
  logic hit1, hit2;
  assign hit1 = (RegWriteE && (WA3E == RA1D)) || (RegWriteM && (WA3M == RA1D));
  assign hit2 = (RegWriteE && (WA3E == RA2D)) || (RegWriteM && (WA3M == RA2D));

  assign ForwardAE = 2'b00;
  assign ForwardBE = 2'b00;
  assign raw_stall = hit1 || hit2;

  logic unused_fwd;
  assign unused_fwd = ^{RA1E, RA2E, WA3W, RegWriteW, PC_REG};
`endif

  // ---------------------------------------------------------------------------
  // Stall / flush
  // A multiply holds E and bubbles M. While it does, E must not be flushed:
  // the stalled multiply would be lost, so StallE overrides FlushE.
  // ---------------------------------------------------------------------------
  assign StallF = ldr_stall || pc_wr_pending || mul_stall || raw_stall;
  assign StallD = ldr_stall || mul_stall || raw_stall;
  assign StallE = mul_stall;

  assign FlushD = pc_wr_pending || PCSrcW || BranchTakenE;
  assign FlushE = (ldr_stall || BranchTakenE || raw_stall) && !mul_stall;
  assign FlushM = mul_stall;

endmodule
